intr_ctrl: RTL and testbench

Memory-mapped interrupt controller on the CPU device bus. It collects up to `N_SRC` peripheral interrupt sources and synchronises them. Each source is edge- or level-triggered, held in software-visible pending/mask registers, and the controller drives one registered request line into one bit of the CPU's `iINTRQ[5:0]`. Software identifies and acknowledges sources through a priority-encoded CLAIM register and write-1-to-clear on PEND.

---
 rtl/intr_pkg.sv | 11 +
 rtl/intr_sync.sv | 27 ++
 rtl/intr_ctrl.sv | 93 +++++++++
 tb/tb_intr_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - register offsets and constants for the interrupt controller
package intr_pkg;

  localparam logic [1:0]  OFF_PEND   = 2'd0;
  localparam logic [1:0]  OFF_MASK   = 2'd1;
  localparam logic [1:0]  OFF_EDGE   = 2'd2;
  localparam logic [1:0]  OFF_CLAIM  = 2'd3;
  localparam int          MAX_SRC    = 32;
  localparam logic [31:0] CLAIM_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - per-source two-flop synchroniser plus a third flop for rising-edge detect
module intr_sync (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic rise,
  output logic lvl
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - memory-mapped interrupt controller: PEND/MASK/EDGE/CLAIM and one irq line
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int          N_SRC = 16,
  parameter logic [31:0] BASE  = 32'h0000_7F20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  output logic [31:0]       rdata_o,
  output logic              hit_o,
  input  logic [N_SRC-1:0]  src_i,
  output logic              irq_o
);

  logic [N_SRC-1:0]   pend_r, mask_r, edge_r;
  logic [N_SRC-1:0]   rise, lvl, w1c, edge_nx, edge_chg, pend_nx, active;
  logic [1:0]         off;
  logic               wr;
  logic [MAX_SRC-1:0] claim;
  logic               unused_bits;

  assign hit_o       = (addr_i[31:4] == BASE[31:4]);
  assign off         = addr_i[3:2];
  assign wr          = hit_o && (be_i == 4'b1111);
  assign w1c         = (wr && off == OFF_PEND) ? wdata_i[N_SRC-1:0] : '0;
  assign edge_nx     = (wr && off == OFF_EDGE) ? wdata_i[N_SRC-1:0] : edge_r;
  assign edge_chg    = edge_nx ^ edge_r;
  assign active      = pend_r & mask_r;
  assign unused_bits = &{1'b0, wdata_i, addr_i[1:0]};

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    intr_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .src   (src_i[g]),
      .rise  (rise[g]),
      .lvl   (lvl[g])
    );
  end

  // A mode switch discards stale pending state; an edge set beats a same-cycle W1C.
  always_comb begin
    pend_nx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (edge_chg[i])
        pend_nx[i] = 1'b0;
      else if (edge_r[i])
        pend_nx[i] = rise[i] | (pend_r[i] & ~w1c[i]);
      else
        pend_nx[i] = lvl[i];
    end
  end

  always_comb begin
    claim = CLAIM_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i])
        claim = 32'(i);
    end
  end

  always_comb begin
    rdata_o = '0;
    if (hit_o) begin
      case (off)
        OFF_PEND: rdata_o = 32'(pend_r);
        OFF_MASK: rdata_o = 32'(mask_r);
        OFF_EDGE: rdata_o = 32'(edge_r);
        default:  rdata_o = claim;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= '0;
      mask_r <= '0;
      edge_r <= '0;
      irq_o  <= 1'b0;
    end else begin
      pend_r <= pend_nx;
      edge_r <= edge_nx;
      irq_o  <= |active;
      if (wr && off == OFF_MASK)
        mask_r <= wdata_i[N_SRC-1:0];
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl against a cycle-level reference model
module tb_intr_ctrl;

  localparam int          N       = 16;
  localparam logic [31:0] BASE    = 32'h0000_7F20;
  localparam logic [31:0] PEND_A  = BASE;
  localparam logic [31:0] MASK_A  = BASE + 32'd4;
  localparam logic [31:0] EDGE_A  = BASE + 32'd8;
  localparam logic [31:0] CLAIM_A = BASE + 32'd12;
  localparam logic [31:0] NONE    = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [3:0]    be = '0;
  logic [N-1:0]  src = '0;
  logic [31:0]   rdata;
  logic          hit, irq;

  intr_ctrl #(.N_SRC(N), .BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .rdata_o (rdata),
    .hit_o   (hit),
    .src_i   (src),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Values to be applied to the pins at the next falling edge.
  logic [31:0]  a_v = '0, wd_v = '0;
  logic [3:0]   be_v = '0;
  logic [N-1:0] s_v = '0;
  logic         rst_v = 1'b0;

  // Reference state: registers as software sees them plus the history of sampled source values.
  logic [N-1:0] pend_m, mask_m, edge_m;
  logic         irq_m;
  logic [N-1:0] smp[$];

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  function automatic logic [31:0] m_claim();
    for (int i = 0; i < N; i++)
      if (pend_m[i] && mask_m[i]) return 32'(i);
    return NONE;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return 32'(pend_m);
      2'd1:    return 32'(mask_m);
      2'd2:    return 32'(edge_m);
      default: return m_claim();
    endcase
  endfunction

  task automatic model_clear();
    pend_m = '0;
    mask_m = '0;
    edge_m = '0;
    irq_m  = 1'b0;
    smp.delete();
    repeat (3) smp.push_back('0);
  endtask

  // smp[1] is the source value two edges ago (what the level path sees), smp[2] three edges ago.
  task automatic model_step();
    logic [N-1:0] now_lvl, now_rise, clr, new_edge, pn;
    bit           store;
    now_lvl  = smp[1];
    now_rise = smp[1] & ~smp[2];
    store    = m_hit(addr) && (be == 4'hF);
    clr      = (store && addr[3:2] == 2'd0) ? wdata[N-1:0] : '0;
    new_edge = (store && addr[3:2] == 2'd2) ? wdata[N-1:0] : edge_m;
    for (int i = 0; i < N; i++) begin
      if (new_edge[i] != edge_m[i])  pn[i] = 1'b0;
      else if (!edge_m[i])           pn[i] = now_lvl[i];
      else if (now_rise[i])          pn[i] = 1'b1;
      else if (clr[i])               pn[i] = 1'b0;
      else                           pn[i] = pend_m[i];
    end
    irq_m = (pend_m & mask_m) != '0;
    if (store && addr[3:2] == 2'd1) mask_m = wdata[N-1:0];
    edge_m = new_edge;
    pend_m = pn;
    smp.push_front(src);
    void'(smp.pop_back());
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    chk_t c;
    c.tag = tag;
    c.sel = sel;
    c.exp = e;
    sb.push_back(c);
  endtask

  // One bus cycle: apply pins at negedge, queue expectations, advance the model on posedge.
  task automatic cyc(input bit ck_rd, input logic [31:0] erd, input bit ck_irq, input bit eirq,
                     input string tag);
    @(negedge clk);
    addr  = a_v;
    wdata = wd_v;
    be    = be_v;
    src   = s_v;
    reset = rst_v;
    #1;
    if (!reset) model_clear();
    push("model_rdata", 0, m_read(addr));
    push("model_hit", 1, 32'(m_hit(addr)));
    push("model_irq", 2, 32'(irq_m));
    if (ck_rd)  push(tag, 0, erd);
    if (ck_irq) push(tag, 2, 32'(eirq));
    @(posedge clk);
    if (reset) model_step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    a_v  = a;
    wd_v = d;
    be_v = 4'hF;
    cyc(0, 0, 0, 0, "");
    be_v = 4'h0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string tag);
    a_v  = a;
    be_v = 4'h0;
    cyc(1, e, 0, 0, tag);
  endtask

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    #2;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.sel)
        0:       act = rdata;
        1:       act = {31'b0, hit};
        default: act = {31'b0, irq};
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s @%0t: got %h want %h", c.tag, $time, act, c.exp);
      end
    end
  end

  initial begin
    model_clear();

    rst_v = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, "");
    rst_v = 1'b1;
    rd_chk(PEND_A, 0, "rst_pend");
    rd_chk(MASK_A, 0, "rst_mask");
    rd_chk(EDGE_A, 0, "rst_edge");
    a_v = CLAIM_A;
    cyc(1, NONE, 1, 0, "rst_claim_irq");

    wr(MASK_A, 32'h1);
    s_v = 16'h0001;
    a_v = PEND_A;
    cyc(1, 0, 1, 0, "lvl_e0");
    cyc(1, 0, 1, 0, "lvl_e1");
    cyc(1, 0, 1, 0, "lvl_e2");
    cyc(1, 1, 1, 0, "lvl_e3");
    a_v = CLAIM_A;
    cyc(1, 0, 1, 1, "lvl_e4_claim");
    s_v = 16'h0000;
    a_v = PEND_A;
    cyc(1, 1, 1, 1, "lvl_d0");
    cyc(1, 1, 1, 1, "lvl_d1");
    cyc(1, 1, 1, 1, "lvl_d2");
    cyc(1, 0, 1, 1, "lvl_d3");
    cyc(1, 0, 1, 0, "lvl_d4");

    wr(EDGE_A, 32'h8);
    wr(MASK_A, 32'h8);
    s_v = 16'h0008;
    a_v = PEND_A;
    cyc(0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, "");
    s_v = 16'h0000;
    cyc(1, 0, 0, 0, "edge_e2");
    repeat (4) cyc(1, 32'h8, 0, 0, "edge_sticky");
    wd_v = 32'h8;
    be_v = 4'hF;
    cyc(1, 32'h8, 1, 1, "w1c_cycle");
    be_v = 4'h0;
    cyc(1, 0, 1, 1, "w1c_next");
    cyc(1, 0, 1, 0, "w1c_irq_fall");

    s_v = 16'h0008;
    cyc(0, 0, 0, 0, "");
    s_v = 16'h0000;
    repeat (5) cyc(0, 0, 0, 0, "");
    rd_chk(PEND_A, 32'h8, "sim_first");
    s_v = 16'h0008;
    cyc(0, 0, 0, 0, "");
    s_v = 16'h0000;
    cyc(0, 0, 0, 0, "");
    wd_v = 32'h8;
    be_v = 4'hF;
    cyc(1, 32'h8, 0, 0, "sim_pre");
    be_v = 4'h0;
    cyc(1, 32'h8, 0, 0, "sim_set_wins");

    s_v = 16'h0224;
    repeat (3) cyc(0, 0, 0, 0, "");
    wr(MASK_A, 32'h0220);
    rd_chk(CLAIM_A, 32'd5, "prio_5");
    wr(MASK_A, 32'h0204);
    rd_chk(CLAIM_A, 32'd2, "prio_2");
    wr(MASK_A, 32'h0);
    a_v = CLAIM_A;
    cyc(1, NONE, 1, 1, "prio_none");
    cyc(1, NONE, 1, 0, "prio_irq_off");

    a_v  = MASK_A;
    wd_v = 32'hFFFF;
    be_v = 4'b0011;
    cyc(0, 0, 0, 0, "");
    rd_chk(MASK_A, 0, "partial_be");
    a_v  = BASE + 32'd16;
    wd_v = 32'hFFFF_FFFF;
    be_v = 4'hF;
    cyc(1, 0, 0, 0, "oob_read");
    rd_chk(MASK_A, 0, "oob_no_write");

    s_v = 16'h0226;
    repeat (3) cyc(0, 0, 0, 0, "");
    rd_chk(PEND_A, 32'h022E, "pend1_set");
    wr(EDGE_A, 32'h000A);
    rd_chk(PEND_A, 32'h022C, "edge_chg_clr");
    rd_chk(PEND_A, 32'h022C, "edge_chg_hold");

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 85)      a_v = BASE + 32'($urandom_range(0, 15));
      else if (r < 97) a_v = BASE - 32'd16 + 32'($urandom_range(0, 63));
      else             a_v = $urandom;
      if ($urandom_range(0, 2) == 0)
        be_v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      else
        be_v = 4'h0;
      wd_v  = $urandom;
      s_v   = s_v ^ N'($urandom & $urandom & $urandom);
      rst_v = !(i == 300 || i == 301);
      cyc(0, 0, 0, 0, "");
    end

    be_v  = 4'h0;
    rst_v = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, "");
    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
